// File: rtl/mult_seq.sv
// Sequential shift-and-add multiplier: WIDTH x WIDTH -> 2*WIDTH over valid/ready,
// with every add and every two's-complement negation routed through one shared adder.

module adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout
);
  logic [WIDTH-1:0] w_g;
  logic [WIDTH-1:0] w_p;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_gp
      assign w_g[gi] = a[gi] & b[gi];
      assign w_p[gi] = a[gi] ^ b[gi];
    end
  endgenerate

  // Carry chain evaluated in one procedural pass so it stays a single acyclic net.
  always_comb begin
    logic c;
    c = cin;
    s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      s[i] = w_p[i] ^ c;
      c    = w_g[i] | (w_p[i] & c);
    end
    cout = c;
  end
endmodule

module mult_seq #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);
  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_NEG_A  = 3'd1;
  localparam logic [2:0] S_NEG_B  = 3'd2;
  localparam logic [2:0] S_CALC   = 3'd3;
  localparam logic [2:0] S_NEG_LO = 3'd4;
  localparam logic [2:0] S_NEG_HI = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  logic [2:0]         r_state;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_neg;
  logic               r_b_neg;
  logic               r_carry;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_product;

  logic [WIDTH-1:0]   w_add_a;
  logic [WIDTH-1:0]   w_add_b;
  logic               w_add_cin;
  logic [WIDTH-1:0]   w_sum;
  logic               w_cout;
  logic               w_a_neg;
  logic               w_b_neg;
  logic               w_last;

  assign w_a_neg   = is_signed & op_a[WIDTH-1];
  assign w_b_neg   = is_signed & op_b[WIDTH-1];
  assign w_last    = (r_cnt == CW'(WIDTH - 1));
  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign product   = r_product;

  // Operand steering for the shared adder; negations are ~x + cin with b = 0.
  always_comb begin
    w_add_a   = '0;
    w_add_b   = '0;
    w_add_cin = 1'b0;
    case (r_state)
      S_NEG_A: begin
        w_add_a   = ~r_mcand;
        w_add_cin = 1'b1;
      end
      S_NEG_B, S_NEG_LO: begin
        w_add_a   = ~r_lo;
        w_add_cin = 1'b1;
      end
      S_CALC: begin
        w_add_a = r_hi;
        w_add_b = r_lo[0] ? r_mcand : '0;
      end
      S_NEG_HI: begin
        w_add_a   = ~r_hi;
        w_add_cin = r_carry;
      end
      default: ;
    endcase
  end

  adder #(.WIDTH(WIDTH)) u_adder (
    .a    (w_add_a),
    .b    (w_add_b),
    .cin  (w_add_cin),
    .s    (w_sum),
    .cout (w_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_mcand   <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_neg     <= 1'b0;
      r_b_neg   <= 1'b0;
      r_carry   <= 1'b0;
      r_cnt     <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_mcand <= op_a;
            r_lo    <= op_b;
            r_hi    <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_neg   <= w_a_neg ^ w_b_neg;
            r_b_neg <= w_b_neg;
            if (w_a_neg)      r_state <= S_NEG_A;
            else if (w_b_neg) r_state <= S_NEG_B;
            else              r_state <= S_CALC;
          end
        end
        S_NEG_A: begin
          r_mcand <= w_sum;
          r_state <= r_b_neg ? S_NEG_B : S_CALC;
        end
        S_NEG_B: begin
          r_lo    <= w_sum;
          r_state <= S_CALC;
        end
        S_CALC: begin
          r_hi  <= {w_cout, w_sum[WIDTH-1:1]};
          r_lo  <= {w_sum[0], r_lo[WIDTH-1:1]};
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            if (r_neg) begin
              r_state <= S_NEG_LO;
            end else begin
              r_state   <= S_DONE;
              r_product <= {w_cout, w_sum, r_lo[WIDTH-1:1]};
            end
          end
        end
        S_NEG_LO: begin
          r_lo    <= w_sum;
          r_carry <= w_cout;
          r_state <= S_NEG_HI;
        end
        S_NEG_HI: begin
          r_hi      <= w_sum;
          r_product <= {w_sum, r_lo};
          r_state   <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/mult_seq.md
# mult_seq

Multi-cycle shift-and-add multiplier for the execute stage. It accepts two WIDTH-bit operands over a valid/ready handshake and returns a 2·WIDTH-bit product over a second valid/ready handshake. All arithmetic goes through one instance of the team's `adder` block (WIDTH-bit CLA with `cin`/`cout`). That includes partial-product accumulation and every two's-complement negation. The block sits upstream of that adder, drives its `a`/`b`/`cin`, and consumes `s`/`cout` each cycle.

## Interface
- WIDTH, 32, operand width; the product is 2·WIDTH bits; passed straight to the `adder` instance.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands and `is_signed` are valid.
- in_ready  out  1  block can accept operands; high only in IDLE.
- is_signed  in  1  1 = two's-complement operands, 0 = unsigned.
- op_a  in  WIDTH  multiplicand.
- op_b  in  WIDTH  multiplier.
- out_valid  out  1  product valid; high only in DONE.
- out_ready  in  1  consumer takes the product.
- product  out  2·WIDTH  result, registered.

## Operation
- Only one adder instance is allowed; no `*` operator and no other `+` on WIDTH-bit data. The cycle counter may use its own small increment.
- Internal registers:
  - `mcand` (WIDTH): magnitude of `op_a`.
  - `hi` (WIDTH) and `lo` (WIDTH): `lo` is initialised with the magnitude of `op_b`.
  - `neg` (1): result sign.
  - `cnt`: iteration counter.
  - `carry` (1): carry for the two-step product negation.
- Accept: `in_valid & in_ready` at a rising edge.
  - Latch `op_a` into `mcand` and `op_b` into `lo`.
  - Clear `hi` and `cnt`.
  - Set `neg = is_signed & (op_a[MSB] ^ op_b[MSB])`.
- States:
  - IDLE: `in_ready` = 1.
  - NEG_A: `mcand` ← `~mcand + 1` (adder a = `~mcand`, b = 0, cin = 1).
  - NEG_B: `lo` ← `~lo + 1`.
  - CALC: adder a = `hi`, b = (`lo[0]` ? `mcand` : 0), cin = 0. Then `{hi, lo}` ← `{cout, s, lo} >> 1`, and `cnt` increments.
  - NEG_LO: `lo` ← `~lo + 1`; `carry` ← `cout`.
  - NEG_HI: `hi` ← `~hi + carry` (b = 0, cin = `carry`).
  - DONE: `product` = `{hi, lo}`; `out_valid` = 1.
- Transitions:
  - IDLE → NEG_A on accept, if `is_signed & op_a[MSB]`.
  - IDLE → NEG_B on accept, if the NEG_A condition is false and `is_signed & op_b[MSB]`.
  - IDLE → CALC on accept, otherwise.
  - NEG_A → NEG_B if the latched `op_b` was negative, else → CALC.
  - NEG_B → CALC.
  - CALC → CALC while `cnt < WIDTH-1`.
  - CALC → NEG_LO after iteration WIDTH-1, if `neg`; else → DONE.
  - NEG_LO → NEG_HI → DONE.
  - DONE → IDLE on `out_ready`.
- Magnitudes are taken as WIDTH-bit unsigned values, so the most-negative operand −2^(WIDTH−1) becomes 2^(WIDTH−1). No overflow is possible in the 2·WIDTH-bit result.
- A negative sign with a zero magnitude still runs NEG_LO/NEG_HI. The result is 0.

## Timing
- Reset (async assert): state = IDLE, `in_ready` = 1, `out_valid` = 0, `product` = 0, all internal registers = 0. Deassertion is synchronous to `clk` via the standard reset path.
- Reset asserted mid-operation aborts immediately. No `out_valid` follows for the aborted operation.
- Latency from the accept edge to the edge that raises `out_valid` is WIDTH + nA + nB + 2·neg cycles:
  - nA = 1 if `op_a` is signed-negative, else 0.
  - nB = 1 if `op_b` is signed-negative, else 0.
  - Unsigned, WIDTH = 32: 32 cycles.
  - Worst case signed, WIDTH = 32: 35 cycles.
- `product` and `out_valid` are held stable while `out_ready` = 0, for an indefinite number of cycles.
- `out_valid & out_ready` at an edge moves the block to IDLE. `in_ready` rises in the following cycle. There is no same-cycle accept in DONE, so the throughput limit is one product per latency + 2 cycles.
- `in_valid` while busy is ignored and not queued. Inputs are sampled only at the accept edge; later changes to `op_a`, `op_b` or `is_signed` have no effect.

## Test plan
- Unsigned 0xFFFFFFFF × 0xFFFFFFFF → `product` = 0xFFFFFFFE00000001, with `out_valid` exactly 32 cycles after accept.
- Signed −3 × 7 (0xFFFFFFFD, 0x00000007) → 0xFFFFFFFFFFFFFFEB (−21), with latency 35 (nA = 1, nB = 0, neg = 1 → 32 + 1 + 2).
- Signed 0x80000000 × 0x80000000 → 0x4000000000000000, with latency 34. Signed −5 × 0 → 0.
- Backpressure: hold `out_ready` = 0 for 10 cycles after `out_valid`.
  - Required: `product` is stable, `in_ready` = 0, and a new `in_valid` is not accepted.
  - After the release edge, `in_ready` = 1 on the next cycle.
- Assert `rst_n` = 0 at cycle 15 of an unsigned 12345 × 6789 operation.
  - Required: outputs go to their reset values immediately.
  - A following 12345 × 6789 run returns 83810205 (0x0000000004FED79D).
- Randomised back-to-back run of 1000 operations, signed and unsigned mixed, with random `out_ready` stalls. Every product must match a reference 64-bit multiply.
